// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encodings and default width.
package serial_add_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_sub_full_add.sv
// Structural full adder built from two half adders and an OR gate.
module half_add_structural (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module full_add_structural (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s_ab;
    logic c_ab;
    logic c_sc;

    half_add_structural u_ha_ab (
        .a     (a),
        .b     (b),
        .sum   (s_ab),
        .carry (c_ab)
    );

    half_add_structural u_ha_sc (
        .a     (s_ab),
        .b     (cin),
        .sum   (sum),
        .carry (c_sc)
    );

    assign cout = c_ab | c_sc;
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for operands, in_ready = 1
//   RUN   | shifting one bit per clock through the full adder
//   DONE  | result presented, waiting for out_ready
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rs_next;
    logic [CW-1:0]    cnt;
    logic             cff;
    logic             s_bit;
    logic             co_bit;
    logic             last_bit;

    full_add_structural u_fa (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (cff),
        .sum  (s_bit),
        .cout (co_bit)
    );

    // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    always_comb begin
        rs_next            = rs >> 1;
        rs_next[WIDTH-1]   = s_bit;
    end

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ra        <= '0;
            rb        <= '0;
            rs        <= '0;
            cnt       <= '0;
            cff       <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra    <= a;
                        rb    <= sub ? ~b : b;
                        cff   <= sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rs  <= rs_next;
                    cff <= co_bit;
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        sum       <= rs_next;
                        carry     <= co_bit;
                        overflow  <= cff ^ co_bit;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random bench for serial_add_sub at WIDTH 8, 1 and 16 with a result scoreboard.
module tb_serial_add_sub;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       iv8 = 0, ir8, sb8 = 0, ov8, or8 = 0, c8, o8;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       iv1 = 0, ir1, sb1 = 0, ov1, or1 = 0, c1, o1;
    logic [0:0] a1 = '0, b1 = '0, s1;
    logic        iv16 = 0, ir16, sb16 = 0, ov16, or16 = 0, c16, o16;
    logic [15:0] a16 = '0, b16 = '0, s16;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .sub(sb8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .carry(c8), .overflow(o8));
    serial_add_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .sub(sb1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1), .overflow(o1));
    serial_add_sub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .sub(sb16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .carry(c16), .overflow(o16));

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed overflow from operand/result signs, independent of carry chain.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] bb;
        logic [63:0] tot;
        mask = (64'd1 << w) - 64'd1;
        bb   = s ? (~b & mask) : (b & mask);
        tot  = (a & mask) + bb + {63'd0, s};
        e.s  = tot & mask;
        e.c  = tot[w];
        e.o  = (a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]);
        return e;
    endfunction

    function automatic int width_of(input int which);
        return (which == 1) ? 1 : (which == 16) ? 16 : 8;
    endfunction

    task automatic drive(input int which, input logic iv, input logic [63:0] a, input logic [63:0] b, input logic s);
        case (which)
            1:  begin iv1  = iv; a1  = a[0:0];  b1  = b[0:0];  sb1  = s; end
            16: begin iv16 = iv; a16 = a[15:0]; b16 = b[15:0]; sb16 = s; end
            default: begin iv8 = iv; a8 = a[7:0]; b8 = b[7:0]; sb8 = s; end
        endcase
    endtask

    task automatic set_ordy(input int which, input logic v);
        case (which)
            1:  or1  = v;
            16: or16 = v;
            default: or8 = v;
        endcase
    endtask

    task automatic sample(input int which, output logic ov, output logic ir,
                          output logic [63:0] s, output logic c, output logic o);
        case (which)
            1:  begin ov = ov1;  ir = ir1;  s = {63'd0, s1};  c = c1;  o = o1;  end
            16: begin ov = ov16; ir = ir16; s = {48'd0, s16}; c = c16; o = o16; end
            default: begin ov = ov8; ir = ir8; s = {56'd0, s8}; c = c8; o = o8; end
        endcase
    endtask

    task automatic run_op(input int which, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input int hold, input string tag);
        int          w;
        int          lat;
        logic        ov, ir, c, o;
        logic [63:0] sm;
        exp_t        e;
        w = width_of(which);
        sample(which, ov, ir, sm, c, o);
        check({tag, "_in_ready_idle"}, {63'd0, ir}, 64'd1);
        drive(which, 1'b1, a, b, s);
        sb_q.push_back(model(w, a, b, s));
        @(posedge clk); #1;
        drive(which, 1'b0, 64'd0, 64'd0, 1'b0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            sample(which, ov, ir, sm, c, o);
        end while (!ov && lat < w + 20);
        check({tag, "_latency"}, 64'(lat), 64'(w));
        if (sb_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_sum"}, sm, e.s);
        check({tag, "_carry"}, {63'd0, c}, {63'd0, e.c});
        check({tag, "_overflow"}, {63'd0, o}, {63'd0, e.o});
        for (int i = 0; i < hold; i++) begin
            drive(which, 1'b1, 64'($urandom), 64'($urandom), 1'($urandom));
            @(posedge clk); #1;
            sample(which, ov, ir, sm, c, o);
            check({tag, "_hold_valid"}, {63'd0, ov}, 64'd1);
            check({tag, "_hold_in_ready"}, {63'd0, ir}, 64'd0);
            check({tag, "_hold_sum"}, sm, e.s);
            check({tag, "_hold_carry"}, {63'd0, c}, {63'd0, e.c});
        end
        drive(which, 1'b0, 64'd0, 64'd0, 1'b0);
        set_ordy(which, 1'b1);
        @(posedge clk); #1;
        set_ordy(which, 1'b0);
        sample(which, ov, ir, sm, c, o);
        check({tag, "_valid_dropped"}, {63'd0, ov}, 64'd0);
        check({tag, "_back_to_idle"}, {63'd0, ir}, 64'd1);
        check({tag, "_sum_kept"}, sm, e.s);
    endtask

    initial begin
        logic        ov, ir, c, o;
        logic [63:0] sm;
        logic        saw_valid;

        // Reset with in_valid asserted
        #1;
        rst = 1'b1;
        iv8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk); @(posedge clk); #1;
        sample(8, ov, ir, sm, c, o);
        check("rst_out_valid", {63'd0, ov}, 64'd0);
        check("rst_sum", sm, 64'd0);
        check("rst_carry", {63'd0, c}, 64'd0);
        check("rst_overflow", {63'd0, o}, 64'd0);
        rst = 1'b0;
        iv8 = 1'b0;
        @(posedge clk); #1;
        sample(8, ov, ir, sm, c, o);
        check("rst_in_ready", {63'd0, ir}, 64'd1);
        check("rst_no_accept", {63'd0, ov}, 64'd0);

        // Basic add and subtract
        run_op(8, 64'h0F, 64'h01, 1'b0, 0, "add_0f_01");
        run_op(8, 64'hFF, 64'h01, 1'b0, 0, "add_ff_01");
        run_op(8, 64'h7F, 64'h01, 1'b0, 0, "add_7f_01");
        run_op(8, 64'h05, 64'h07, 1'b1, 0, "sub_05_07");
        run_op(8, 64'h80, 64'h01, 1'b1, 0, "sub_80_01");

        // Backpressure with ignored in_valid pulses, then a follow-on op
        run_op(8, 64'h3C, 64'hC4, 1'b0, 5, "bp");
        run_op(8, 64'h10, 64'h20, 1'b1, 0, "after_bp");

        // Reset on the 3rd RUN edge
        drive(8, 1'b1, 64'h44, 64'h55, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 64'd0, 64'd0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sample(8, ov, ir, sm, c, o);
            if (ov) saw_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_valid", {63'd0, saw_valid}, 64'd0);
        sample(8, ov, ir, sm, c, o);
        check("abort_idle", {63'd0, ir}, 64'd1);
        check("abort_sum_reset", sm, 64'd0);
        check("abort_carry_reset", {63'd0, c}, 64'd0);
        run_op(8, 64'h22, 64'h11, 1'b0, 0, "post_abort");

        // WIDTH = 1
        run_op(1, 64'h1, 64'h1, 1'b0, 0, "w1_add_1_1");
        run_op(1, 64'h1, 64'h0, 1'b1, 1, "w1_sub_1_0");
        run_op(1, 64'h0, 64'h1, 1'b1, 0, "w1_sub_0_1");

        // WIDTH = 16 corners, then random ops
        run_op(16, 64'hFFFF, 64'h0001, 1'b0, 0, "w16_wrap");
        run_op(16, 64'h8000, 64'h0001, 1'b1, 0, "w16_minneg");
        for (int i = 0; i < 200; i++) begin
            run_op(16, 64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "w16_rand");
        end

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
